hazard_stall_controller: RTL
============================

// Module: hazard_stall_controller
// PURPOSE
//  Parametrised hazard unit for the 5-stage pipeline; sits beside the ID stage.
//  Detects RAW hazards against the EX and MEM producers and holds PC and IF/ID for a
//  computed multi-cycle stall. Issues a bubble through the control mux, and drives a
//  multi-cycle IF flush on a taken branch or jump. Counts stall and flush cycles for
//  the performance registers.
// PARAMETERS
//  AW          5  register-address width
//  FWD_EN      1  1 = forwarding present (only load-use stalls); 0 = stall on any RAW
//  LOAD_STALL  1  stall cycles for a load in EX with a dependent ID instruction (1..7)
//  FLUSH_CYC   1  IF flush cycles per taken branch/jump (1..7)
//  ZERO_EXEMPT 1  1 = register 0 never creates a hazard
//  CW          16 width of the performance counters
// PORTS
//  Clk           in  1   pipeline clock, all state on rising edge
//  Reset         in  1   synchronous, active-high
//  IF_ID_Rs      in  AW  source register A of the ID instruction
//  IF_ID_Rt      in  AW  source register B of the ID instruction
//  id_uses_rs    in  1   ID instruction actually reads Rs
//  id_uses_rt    in  1   ID instruction actually reads Rt
//  ID_EX_Dst     in  AW  destination register of the EX instruction
//  ID_EX_RegWrite in 1   EX instruction writes a register
//  ID_EX_MemRead in  1   EX instruction is a load
//  EX_MEM_Dst    in  AW  destination register of the MEM instruction
//  EX_MEM_RegWrite in 1  MEM instruction writes a register
//  EX_MEM_MemRead in 1   MEM instruction is a load
//  branch        in  1   taken branch resolved in ID
//  jump          in  1   jump/jr/jal decoded in ID
//  PCWrite       out 1   1 = PC may update
//  IF_ID_Write   out 1   1 = IF/ID may load
//  ControlMux    out 1   1 = pass ID control; 0 = insert bubble into ID/EX
//  IF_Flush      out 1   1 = zero the IF/ID register
//  stall_cycles  out CW  saturating count of stall cycles since reset
//  flush_cycles  out CW  saturating count of flush cycles since reset
// BEHAVIOUR
//  - Match terms: depX = RegWrite_X & (uses_rs&Dst_X==Rs | uses_rt&Dst_X==Rt) & !(ZERO_EXEMPT & Dst_X==0).
//  - Required stall req (IDLE only):
//      FWD_EN=1: depEX&ID_EX_MemRead -> LOAD_STALL;
//                depMEM&EX_MEM_MemRead -> LOAD_STALL-1; else 0.
//      FWD_EN=0: depEX -> 2; depMEM -> 1; else 0.
//      Take the maximum when several terms apply.
//  - FSM: IDLE, STALL, FLUSH; 3-bit down-counter cnt.
//  - IDLE, req>0: same-cycle PCWrite=0, IF_ID_Write=0, ControlMux=0, IF_Flush=0.
//    If req>1: next STALL with cnt=req-2; else stay IDLE.
//  - IDLE, req=0, branch|jump: same-cycle PCWrite=1, IF_ID_Write=1, ControlMux=1, IF_Flush=1.
//    If FLUSH_CYC>1: next FLUSH with cnt=FLUSH_CYC-2.
//  - IDLE, no event: PCWrite=1, IF_ID_Write=1, ControlMux=1, IF_Flush=0.
//  - Data hazard beats branch/jump in the same cycle. The branch stays in ID and is
//    re-evaluated once the stall ends.
//  - STALL: stall outputs as above; all ID/EX/MEM inputs ignored.
//    cnt==0 -> IDLE, else cnt-1.
//  - FLUSH: PCWrite=1, IF_ID_Write=1, ControlMux=1, IF_Flush=1; branch/jump ignored.
//    cnt==0 -> IDLE, else cnt-1.
//  - Counters: +1 per cycle with PCWrite=0 (stall) or IF_Flush=1 (flush); saturate at all-ones.
//  - Reset high: next state IDLE, cnt=0, both counters 0.
//    During the Reset cycle: PCWrite=0, IF_ID_Write=0, ControlMux=0, IF_Flush=1.
//  - Reset mid-STALL or mid-FLUSH aborts it; the first cycle after Reset is plain IDLE evaluation.
// TESTING
//  1. FWD_EN=1, LOAD_STALL=1: ID_EX_MemRead=1, ID_EX_RegWrite=1, Dst=5, Rs=5, uses_rs=1
//     -> one cycle PCWrite=0, ControlMux=0; next cycle all 1; stall_cycles=1.
//  2. LOAD_STALL=3, same load-use -> PCWrite=0 for exactly 3 cycles even if inputs change
//     after cycle 1; stall_cycles=3.
//  3. FWD_EN=0: ALU write Dst=7 in EX, Rt=7 -> 2 stall cycles. With Dst=7 only in MEM
//     -> 1 stall cycle. With Dst=0 (ZERO_EXEMPT=1) -> none.
//  4. FLUSH_CYC=2: branch=1 for one cycle, no hazard -> IF_Flush=1 for 2 cycles,
//     PCWrite=1 throughout; flush_cycles=2.
//  5. Load-use and branch=1 together -> stall first (IF_Flush=0). Flush starts the
//     cycle after the stall ends, with branch still high.
//  6. Reset asserted in cycle 2 of a 3-cycle stall -> Reset-cycle outputs as specified;
//     next cycle IDLE with PCWrite=1 and both counters 0; CW=2 counters saturate at 3.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Hazard unit beside the ID stage: detects RAW hazards against the EX and MEM
// producers, holds PC and IF/ID for a computed multi-cycle stall, inserts
// bubbles through the control mux, drives a multi-cycle IF flush on a taken
// branch or jump, and keeps saturating stall/flush cycle counters.
module hazard_stall_controller #(
  parameter int AW          = 5,
  parameter int FWD_EN      = 1,
  parameter int LOAD_STALL  = 1,
  parameter int FLUSH_CYC   = 1,
  parameter int ZERO_EXEMPT = 1,
  parameter int CW          = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [AW-1:0] IF_ID_Rs,
  input  logic [AW-1:0] IF_ID_Rt,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic [AW-1:0] ID_EX_Dst,
  input  logic          ID_EX_RegWrite,
  input  logic          ID_EX_MemRead,
  input  logic [AW-1:0] EX_MEM_Dst,
  input  logic          EX_MEM_RegWrite,
  input  logic          EX_MEM_MemRead,
  input  logic          branch,
  input  logic          jump,
  output logic          PCWrite,
  output logic          IF_ID_Write,
  output logic          ControlMux,
  output logic          IF_Flush,
  output logic [CW-1:0] stall_cycles,
  output logic [CW-1:0] flush_cycles
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Stall lengths as 4-bit quantities so req can hold up to 7 without overflow.
  localparam logic [3:0] LOAD_REQ  = 4'(LOAD_STALL);
  localparam logic [3:0] MEM_REQ   = 4'(LOAD_STALL - 1);
  // Counter preload so that the FLUSH state adds FLUSH_CYC-1 cycles after IDLE.
  localparam logic [2:0] FLUSH_CNT = 3'((FLUSH_CYC > 1) ? (FLUSH_CYC - 2) : 0);

  state_t     state, state_next;
  logic [2:0] cnt, cnt_next;
  logic       dep_ex, dep_mem;
  logic [3:0] req;

  // Source/destination match terms for the EX and MEM producers.
  always_comb begin
    dep_ex  = ID_EX_RegWrite &&
              ((id_uses_rs && (ID_EX_Dst == IF_ID_Rs)) ||
               (id_uses_rt && (ID_EX_Dst == IF_ID_Rt))) &&
              !((ZERO_EXEMPT != 0) && (ID_EX_Dst == '0));
    dep_mem = EX_MEM_RegWrite &&
              ((id_uses_rs && (EX_MEM_Dst == IF_ID_Rs)) ||
               (id_uses_rt && (EX_MEM_Dst == IF_ID_Rt))) &&
              !((ZERO_EXEMPT != 0) && (EX_MEM_Dst == '0));
  end

  // Required stall length; the longest applicable term wins.
  always_comb begin
    req = 4'd0;
    if (FWD_EN != 0) begin
      if (dep_mem && EX_MEM_MemRead) req = MEM_REQ;
      if (dep_ex && ID_EX_MemRead && (LOAD_REQ > req)) req = LOAD_REQ;
    end else begin
      if (dep_mem) req = 4'd1;
      if (dep_ex)  req = 4'd2;
    end
  end

  // Next-state and pipeline-control outputs; Reset forces the safe hold/flush pattern.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    ControlMux  = 1'b1;
    IF_Flush    = 1'b0;
    if (Reset) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ControlMux  = 1'b0;
      IF_Flush    = 1'b1;
      state_next  = IDLE;
      cnt_next    = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 4'd0) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ControlMux  = 1'b0;
            if (req > 4'd1) begin
              state_next = STALL;
              cnt_next   = 3'(req - 4'd2);
            end
          end else if (branch || jump) begin
            IF_Flush = 1'b1;
            if (FLUSH_CYC > 1) begin
              state_next = FLUSH;
              cnt_next   = FLUSH_CNT;
            end
          end
        end
        STALL: begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          ControlMux  = 1'b0;
          if (cnt == 3'd0) state_next = IDLE;
          else             cnt_next   = cnt - 3'd1;
        end
        FLUSH: begin
          IF_Flush = 1'b1;
          if (cnt == 3'd0) state_next = IDLE;
          else             cnt_next   = cnt - 3'd1;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 3'd0;
        end
      endcase
    end
  end

  // State register and down-counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (!PCWrite && (stall_cycles != '1)) stall_cycles <= stall_cycles + CW'(1);
      if (IF_Flush && (flush_cycles != '1)) flush_cycles <= flush_cycles + CW'(1);
    end
  end

endmodule
